ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
Initiator for the team's single-port RAM interface (en / wr_rd / addr / data_in out; data_out / en_out back). It accepts read and write commands from an upstream client through a valid/ready command port and buffers them in a small FIFO. It issues the commands to the RAM one at a time, waits for the RAM read strobe, and returns read data or a timeout error on a valid/ready response port. It sits between bus-side logic and the RAM instance.

Parameters:
DATA_WIDTH, 8, width of RAM data words
ADDR_WIDTH, 4, width of RAM address
CMD_DEPTH, 4, command FIFO entries (power of 2, at least 2)
TIMEOUT, 8, cycles spent in WAIT_RD without ram_en_out before an error response (at least 2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  upstream command present
cmd_ready  out  1  command FIFO can accept a command
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  read response present
rsp_ready  in  1  upstream accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 when rsp_err=1)
rsp_err  out  1  read timed out
ram_en  out  1  RAM enable, one-cycle pulse per command
ram_wr_rd  out  1  1 = write, 0 = read
ram_addr  out  ADDR_WIDTH  RAM address
ram_data_in  out  DATA_WIDTH  RAM write data
ram_data_out  in  DATA_WIDTH  RAM read data
ram_en_out  in  1  RAM read-data-valid strobe
fifo_count  out  log2(CMD_DEPTH)+1  commands currently buffered

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, FSM in IDLE, timeout counter 0. All outputs go to 0 except cmd_ready, which is 1. ram_en drops immediately. Any in-flight command and pending response are discarded.
- Command port: a push occurs on a posedge with cmd_valid & cmd_ready. cmd_ready = !full, registered from the count, with no same-cycle pass-through. A push and a pop on the same edge leave fifo_count unchanged.
- All ram_* outputs are registered. While ram_en=0, ram_addr, ram_wr_rd and ram_data_in hold their last values.
- FSM states are IDLE, ISSUE, WAIT_RD and RESP.
- IDLE: if the FIFO is non-empty, the next edge pops the head, loads ram_addr / ram_wr_rd / ram_data_in, sets ram_en=1 and moves to ISSUE. Otherwise the FSM stays in IDLE.
- ISSUE: ram_en is high for exactly this cycle, and the RAM samples the command on the next edge. On that edge ram_en goes to 0.
  - Write: go to IDLE. Writes produce no response.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD: the RAM raises ram_en_out on the same edge the FSM enters WAIT_RD, so it is normally seen in the first WAIT_RD cycle.
  - If ram_en_out=1 on an edge: capture ram_data_out into rsp_rdata, set rsp_err=0, rsp_valid=1, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with ram_en_out still 0: rsp_rdata=0, rsp_err=1, rsp_valid=1, go to RESP.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until an edge with rsp_ready=1. On that edge rsp_valid goes to 0 and the FSM goes to IDLE. No new RAM command is issued while in RESP.
- ram_en_out is ignored in every state except WAIT_RD. A late strobe after a timeout does not create a second response.
- Latency:
  - Read, empty FIFO and rsp_ready=1: push at edge N, ram_en high during N+1..N+2, rsp_valid at edge N+3.
  - Write: push at N, ram_en high during N+1..N+2.
- Throughput: one write every 2 cycles. One read every 4 cycles when rsp_ready=1.
- Commands are executed strictly in FIFO order. A read after a write to the same address returns the written data.
- FIFO read/write pointers wrap modulo CMD_DEPTH. fifo_count ranges 0..CMD_DEPTH.

Test Plan:
1. Reset: assert rst=0 mid-simulation -> ram_en, rsp_valid, rsp_err and fifo_count are 0 immediately and cmd_ready=1; after release, no RAM activity with an empty FIFO.
2. Write then read: push W(addr=3, data=A5) then R(addr=3) into a RAM model -> one ram_en pulse with ram_wr_rd=1, addr=3, data_in=A5; a second pulse with ram_wr_rd=0; rsp_valid with rsp_rdata=A5, rsp_err=0; ram_en is never high for 2 consecutive cycles.
3. FIFO full: hold rsp_ready=0 after a read response is pending, then push 4 writes -> fifo_count=4 and cmd_ready=0; a 5th cmd_valid is not accepted; after rsp_ready=1 the 4 writes issue in order to addresses 0,1,2,3.
4. Response backpressure: read addr=7 (data 3C) with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_rdata=3C held stable all 5 cycles; cleared one edge after rsp_ready=1.
5. Timeout: tie ram_en_out=0 and issue a read -> rsp_valid after TIMEOUT=8 WAIT_RD cycles with rsp_err=1, rsp_rdata=0; a later ram_en_out pulse produces no extra response.
6. Async reset in WAIT_RD: drop rst during WAIT_RD with 2 commands queued -> no response, FIFO empty, and the queued commands are never issued after reset release.

Source files
------------

// File: rtl/ram_master.sv
// rtl/ram_master.sv - command-queued initiator for the single-port RAM interface
// Buffers read/write commands, issues them one at a time and returns read data or a timeout error.
module ram_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]        cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         ram_en,
    output logic                         ram_wr_rd,
    output logic [ADDR_WIDTH-1:0]        ram_addr,
    output logic [DATA_WIDTH-1:0]        ram_data_in,
    input  logic [DATA_WIDTH-1:0]        ram_data_out,
    input  logic                         ram_en_out,
    output logic [$clog2(CMD_DEPTH):0]   fifo_count
);
    localparam int PTR_W   = $clog2(CMD_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TO_W    = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [TO_W-1:0]     to_cnt;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;

    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign head       = fifo_mem[rd_ptr];
    assign fifo_count = count;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
        end
    end

    // cmd_ready is a flop so a pop never opens the port in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            cmd_ready <= (count_next != CNT_W'(CMD_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            ram_en      <= 1'b0;
            ram_wr_rd   <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        ram_en      <= 1'b1;
                        ram_wr_rd   <= head[ENTRY_W-1];
                        ram_addr    <= head[DATA_WIDTH +: ADDR_WIDTH];
                        ram_data_in <= head[DATA_WIDTH-1:0];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en <= 1'b0;
                    if (ram_wr_rd) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= '0;
                        state  <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (ram_en_out) begin
                        rsp_rdata <= ram_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural RAM model
module tb_ram_master;
    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       ram_en, ram_wr_rd;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in, ram_data_out;
    logic       ram_en_out;
    logic [2:0] fifo_count;

    logic [7:0] ram_mem [16];
    logic [7:0] shadow [16];
    logic [7:0] model_dout;
    logic       model_en_out;
    logic       stall_ram, late_pulse;

    cmd_t obs_cmd[$], exp_cmd[$];
    rsp_t obs_rsp[$], exp_rsp[$];
    logic prev_en = 1'b0;
    int   en_double = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CMD_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_en_out(ram_en_out), .fifo_count(fifo_count)
    );

    // RAM model: write on en, read data and strobe one edge after en
    always @(posedge clk) begin
        if (ram_en && ram_wr_rd) ram_mem[ram_addr] <= ram_data_in;
        if (ram_en && !ram_wr_rd) model_dout <= ram_mem[ram_addr];
        model_en_out <= ram_en && !ram_wr_rd && !stall_ram;
    end
    assign ram_data_out = model_dout;
    assign ram_en_out   = model_en_out | late_pulse;

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (rst === 1'b1) begin
            if (ram_en) begin
                c.wr = ram_wr_rd; c.addr = ram_addr; c.data = ram_data_in;
                obs_cmd.push_back(c);
            end
            if (ram_en && prev_en) en_double++;
            if (rsp_valid && rsp_ready) begin
                r.err = rsp_err; r.data = rsp_rdata;
                obs_rsp.push_back(r);
            end
        end
        prev_en = ram_en;
    end

    task automatic push(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                        input int budget, output bit ok);
        cmd_t c;
        rsp_t r;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (ok) begin
            c.wr = wr; c.addr = addr; c.data = data;
            exp_cmd.push_back(c);
            if (wr) begin
                shadow[addr] = data;
            end else begin
                r.err  = stall_ram;
                r.data = stall_ram ? 8'h00 : shadow[addr];
                exp_rsp.push_back(r);
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (fifo_count == 0 && !rsp_valid && !ram_en &&
                obs_cmd.size() == exp_cmd.size() && obs_rsp.size() == exp_rsp.size()) ok = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rsp_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: ram_en=%b rsp_valid=%b rsp_err=%b fifo_count=%0d cmd_ready=%b required 0 0 0 0 1",
                     ram_en, rsp_valid, rsp_err, fifo_count, cmd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        push(1'b0, 4'd0, 8'h00, 5, ok);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1) begin
            errors++; $display("FAIL reset_pre_issue: ram_en=%b required 1", ram_en);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ram_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: ram_en=%b rsp_valid=%b rsp_err=%b fifo_count=%0d cmd_ready=%b required 0 0 0 0 1",
                     ram_en, rsp_valid, rsp_err, fifo_count, cmd_ready);
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (obs_cmd.size() != 0 || obs_rsp.size() != 0) begin
            errors++; $display("FAIL reset_idle: ram cmds=%0d rsps=%0d required 0 0", obs_cmd.size(), obs_rsp.size());
        end
    endtask

    task automatic test_write_read();
        bit ok1, ok2, ok;
        cmd_t oc, ec;
        rsp_t orr, er;
        rsp_ready = 1'b1;
        push(1'b1, 4'd3, 8'hA5, 5, ok1);
        push(1'b0, 4'd3, 8'h00, 5, ok2);
        wait_drain(ok);
        checks++;
        if (!(ok1 && ok2 && ok)) begin
            errors++; $display("FAIL wr_rd_progress: accepted=%b%b drained=%b required 111", ok1, ok2, ok);
        end
        checks++;
        if (obs_cmd.size() != 2 || obs_rsp.size() != 1) begin
            errors++; $display("FAIL wr_rd_counts: cmds=%0d rsps=%0d required 2 1", obs_cmd.size(), obs_rsp.size());
        end
        while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
            oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front();
            checks++;
            if (oc !== ec) begin
                errors++; $display("FAIL wr_rd_cmd: got wr=%b addr=%0h data=%0h required wr=%b addr=%0h data=%0h",
                                   oc.wr, oc.addr, oc.data, ec.wr, ec.addr, ec.data);
            end
        end
        while (obs_rsp.size() > 0 && exp_rsp.size() > 0) begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL wr_rd_rsp: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
        checks++;
        if (en_double != 0) begin
            errors++; $display("FAIL wr_rd_en_pulse: consecutive ram_en cycles=%0d required 0", en_double);
        end
    endtask

    task automatic test_latency();
        bit ok;
        logic [3:0] en_pat, val_pat;
        rsp_t orr, er;
        rsp_ready = 1'b1;
        push(1'b0, 4'd3, 8'h00, 5, ok);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            en_pat[3-k]  = ram_en;
            val_pat[3-k] = rsp_valid;
            @(posedge clk); #1;
        end
        checks++;
        if (en_pat !== 4'b0100 || val_pat !== 4'b0001) begin
            errors++; $display("FAIL latency: ram_en=%b rsp_valid=%b required 0100 0001", en_pat, val_pat);
        end
        wait_drain(ok);
        checks++;
        if (!ok || obs_rsp.size() != 1 || exp_rsp.size() != 1) begin
            errors++; $display("FAIL latency_drain: drained=%b rsps=%0d required 1 1", ok, obs_rsp.size());
        end else begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL latency_rsp: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
    endtask

    task automatic test_fifo_full();
        bit ok, okw, ok5;
        cmd_t oc, ec;
        rsp_t orr, er;
        rsp_ready = 1'b0;
        push(1'b0, 4'd3, 8'h00, 5, ok);
        wait_rsp_valid(20, ok);
        okw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 4'(i), 8'h10 + 8'(i), 3, ok);
            okw &= ok;
        end
        @(negedge clk);
        checks++;
        if (!okw || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL full_state: accepted=%b fifo_count=%0d cmd_ready=%b required 1 4 0", okw, fifo_count, cmd_ready);
        end
        @(posedge clk); #1;
        push(1'b1, 4'd9, 8'hEE, 3, ok5);
        checks++;
        if (ok5 !== 1'b0) begin
            errors++; $display("FAIL full_reject: fifth push accepted=%b required 0", ok5);
        end
        rsp_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || obs_cmd.size() != 5 || obs_rsp.size() != 1) begin
            errors++; $display("FAIL full_drain: drained=%b cmds=%0d rsps=%0d required 1 5 1", ok, obs_cmd.size(), obs_rsp.size());
        end
        while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
            oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front();
            checks++;
            if (oc !== ec) begin
                errors++; $display("FAIL full_order: got wr=%b addr=%0h data=%0h required wr=%b addr=%0h data=%0h",
                                   oc.wr, oc.addr, oc.data, ec.wr, ec.addr, ec.data);
            end
        end
        while (obs_rsp.size() > 0 && exp_rsp.size() > 0) begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL full_rsp: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_t orr, er;
        rsp_ready = 1'b1;
        push(1'b1, 4'd7, 8'h3C, 5, ok);
        rsp_ready = 1'b0;
        push(1'b0, 4'd7, 8'h00, 5, ok);
        wait_rsp_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_wait: rsp_valid seen=%b required 1", ok);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b rdata=%0h err=%b required 1 3c 0", i, rsp_valid, rsp_rdata, rsp_err);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_clear: rsp_valid=%b required 0", rsp_valid);
        end
        @(posedge clk); #1;
        wait_drain(ok);
        checks++;
        if (!ok || obs_rsp.size() != 1 || exp_rsp.size() != 1) begin
            errors++; $display("FAIL bp_count: drained=%b rsps=%0d required 1 1", ok, obs_rsp.size());
        end else begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL bp_rsp: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        rsp_t orr, er;
        rsp_ready = 1'b1;
        stall_ram = 1'b1;
        push(1'b0, 4'd5, 8'h00, 5, ok);
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        checks++;
        if (k != 11) begin
            errors++; $display("FAIL timeout_latency: rsp_valid at negedge %0d required 11", k);
        end
        @(posedge clk); #1;
        stall_ram  = 1'b0;
        late_pulse = 1'b1;
        @(posedge clk); #1;
        late_pulse = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (obs_rsp.size() != 1 || exp_rsp.size() != 1) begin
            errors++; $display("FAIL timeout_count: rsps=%0d required 1", obs_rsp.size());
        end else begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL timeout_rsp: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
    endtask

    task automatic test_reset_wait_rd();
        bit ok;
        logic [7:0] save8, save9;
        rsp_t orr, er;
        rsp_ready = 1'b1;
        push(1'b1, 4'd8, 8'h55, 5, ok);
        wait_drain(ok);
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
        save8 = shadow[8]; save9 = shadow[9];
        stall_ram = 1'b1;
        push(1'b0, 4'd2, 8'h00, 5, ok);
        push(1'b1, 4'd8, 8'h77, 5, ok);
        push(1'b1, 4'd9, 8'h88, 5, ok);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++; $display("FAIL rwait_queued: fifo_count=%0d required 2", fifo_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1 || ram_en !== 1'b0) begin
            errors++; $display("FAIL rwait_reset: rsp_valid=%b fifo_count=%0d cmd_ready=%b ram_en=%b required 0 0 1 0",
                               rsp_valid, fifo_count, cmd_ready, ram_en);
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
        shadow[8] = save8; shadow[9] = save9;
        stall_ram = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (obs_cmd.size() != 0 || obs_rsp.size() != 0) begin
            errors++; $display("FAIL rwait_discard: cmds=%0d rsps=%0d required 0 0", obs_cmd.size(), obs_rsp.size());
        end
        push(1'b0, 4'd8, 8'h00, 5, ok);
        wait_drain(ok);
        checks++;
        if (!ok || obs_rsp.size() != 1 || exp_rsp.size() != 1) begin
            errors++; $display("FAIL rwait_readback_count: drained=%b rsps=%0d required 1 1", ok, obs_rsp.size());
        end else begin
            orr = obs_rsp.pop_front(); er = exp_rsp.pop_front();
            checks++;
            if (orr !== er) begin
                errors++; $display("FAIL rwait_readback: got err=%b data=%0h required err=%b data=%0h", orr.err, orr.data, er.err, er.data);
            end
        end
        obs_cmd.delete(); exp_cmd.delete(); obs_rsp.delete(); exp_rsp.delete();
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; stall_ram = 1'b0; late_pulse = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_latency();
        test_fifo_full();
        test_backpressure();
        test_timeout();
        test_reset_wait_rd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
